instruction_fetch: RTL
======================

# instruction_fetch

Front-end fetch stage feeding the instruction queue. Holds the architectural fetch PC, looks it up in a direct-mapped word-granular instruction cache, and on a miss requests the word from the memory controller. Pushes one instruction per cycle into the queue while the queue is not full. Redirects to a new PC when the pipeline is cleared (branch mispredict / exception).

## Interface
Parameters:
- ICACHE_IDX_W, 7: index width; 2^7 = 128 one-word lines. Index = pc[ICACHE_IDX_W+1:2], tag = pc[31:ICACHE_IDX_W+2].

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global enable; low freezes all state except clear/reset handling.
- clear  in  1  pipeline flush, synchronous, honoured regardless of rdy.
- clear_pc  in  32  redirect target, valid with clear.
- IQ_queue_is_full  in  1  queue full flag (asserted with ≤2 free slots).
- IQ_inst_valid  out  1  push strobe to queue.
- IQ_inst  out  32  instruction word.
- IQ_pc  out  32  PC of IQ_inst.
- MC_req_valid  out  1  fetch request to memory controller, level, held until ack.
- MC_addr  out  32  word address of request (pc, low 2 bits 0).
- MC_ack  in  1  one-cycle pulse, MC_inst valid.
- MC_inst  in  32  fetched word.

## Operation
- State machine, two states: IDLE (lookup), MISS (waiting on memory).
- IDLE, edge with rdy=1, clear=0:
  - queue full → IQ_inst_valid<=0, pc unchanged.
  - hit (line valid, tag match) and not full → IQ_inst<=line data, IQ_pc<=pc, IQ_inst_valid<=1, pc<=pc+4 (32-bit wrap).
  - miss and not full → IQ_inst_valid<=0, MC_req_valid<=1, MC_addr<=pc, state<=MISS.
- MISS: MC_req_valid and MC_addr held. IQ_inst_valid<=0. On MC_ack, write {valid=1, tag, MC_inst} at index; MC_req_valid<=0; state<=IDLE. pc unchanged; the next IDLE cycle hits.
- clear (edge, any rdy): pc<=clear_pc, IQ_inst_valid<=0, MC_req_valid<=0, state<=IDLE. Cache contents retained. MC_ack in the same cycle is ignored (no fill). The memory controller also flushes on clear, so no stale ack follows.
- rdy=0: pc, state, cache, MC_* and all IQ_* outputs hold. The queue samples only on rdy-high edges, so a held IQ_inst_valid=1 is consumed exactly once at the next rdy-high edge.
- Priority: rst > clear > rdy gating > normal operation.
- Reset values: pc=0, state=IDLE, IQ_inst_valid=0, IQ_inst=0, IQ_pc=0, MC_req_valid=0, MC_addr=0, all cache valid bits=0.

## Timing
- Hit: PC present at edge t → IQ_inst_valid=1 after edge t+1; sustained throughput 1 instr/cycle.
- Miss: MC_req_valid rises after edge t. Ack at edge a fills the cache. Hit push appears after edge a+1 (if not full).
- Outputs are registered. The queue's 2-slot full margin absorbs the single in-flight push decided one cycle before full is seen.
- Cache lookup is combinational from pc. Fill is written at the ack edge.

## Structure
- cpu_define.v gains `ICacheIdxBus, `ICacheTagBus, `IFStateIdle / `IFStateMiss encodings, and `IFStateBus. `InstBus / `AddressBus are reused.
- Sub-module icache: valid/tag/data arrays, combinational read (hit, data) on address, single write port, async-reset clear of valid bits.

## Test plan
- Reset then cold start at pc 0x0: MC_req_valid=1, MC_addr=0x0. Ack with 0x00000013 → one cycle later IQ_inst_valid=1, IQ_inst=0x00000013, IQ_pc=0x0. Then MC_addr=0x4 requested.
- Warm loop over 0x0–0xC (all filled): 4 consecutive cycles IQ_inst_valid=1, IQ_pc 0x0,0x4,0x8,0xC, no MC_req_valid.
- Hold IQ_queue_is_full=1 for 5 cycles during hits: no pushes, pc frozen. Deassert → next cycle pushes resume at the held pc, no instruction skipped or duplicated.
- Assert clear with clear_pc=0x1000 while in MISS (MC_ack same cycle, data 0xDEADBEEF): MC_req_valid drops, line 0x0 not filled. Next request MC_addr=0x1000.
- Aliasing: fill 0x0 then fetch 0x200 (same index, tag differs) → miss, refill. A later fetch of 0x0 misses again.
- rdy low for 3 cycles while IQ_inst_valid=1 at pc 0x8: outputs held. On rdy high, exactly one push of pc 0x8, then 0xC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch front end.
// Holds the fetch FSM encoding and the word-address helper.
package instruction_fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_MISS = 1'b1
  } if_state_e;

  function automatic logic [XLEN-1:0] word_addr(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Combinational read port, single write port, valid bits async-cleared.
module instruction_fetch_icache
  import instruction_fetch_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:2] addr,
  output logic            hit,
  output logic [XLEN-1:0] data,
  input  logic            we,
  input  logic [XLEN-1:2] waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [XLEN-1:0]  words [LINES];

  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic [TAG_W-1:0] rtag;
  logic [TAG_W-1:0] wtag;

  assign ridx = addr[IDX_W+1:2];
  assign rtag = addr[XLEN-1:IDX_W+2];
  assign widx = waddr[IDX_W+1:2];
  assign wtag = waddr[XLEN-1:IDX_W+2];

  assign hit  = valid[ridx] && (tags[ridx] == rtag);
  assign data = words[ridx];

  // Valid bits: cleared by reset, set on fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  // Tag and data storage, written on fill only.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx]  <= wtag;
      words[widx] <= wdata;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, icache lookup, miss handling.
// Pushes one instruction per cycle into the queue on hits.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            clear,
  input  logic [XLEN-1:0] clear_pc,
  input  logic            IQ_queue_is_full,
  output logic            IQ_inst_valid,
  output logic [XLEN-1:0] IQ_inst,
  output logic [XLEN-1:0] IQ_pc,
  output logic            MC_req_valid,
  output logic [XLEN-1:0] MC_addr,
  input  logic            MC_ack,
  input  logic [XLEN-1:0] MC_inst
);

  if_state_e       state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] inst_n, iq_pc_n, addr_n;
  logic            valid_n, req_n;
  logic            hit, fill;
  logic [XLEN-1:0] line;

  instruction_fetch_icache #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk   (clk),
    .rst   (rst),
    .addr  (pc[XLEN-1:2]),
    .hit   (hit),
    .data  (line),
    .we    (fill),
    .waddr (pc[XLEN-1:2]),
    .wdata (MC_inst)
  );

  // State, PC and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IF_IDLE;
      pc            <= '0;
      IQ_inst_valid <= 1'b0;
      IQ_inst       <= '0;
      IQ_pc         <= '0;
      MC_req_valid  <= 1'b0;
      MC_addr       <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      IQ_inst_valid <= valid_n;
      IQ_inst       <= inst_n;
      IQ_pc         <= iq_pc_n;
      MC_req_valid  <= req_n;
      MC_addr       <= addr_n;
    end
  end

  // Next state: clear wins, rdy low holds everything.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = IQ_inst_valid;
    inst_n  = IQ_inst;
    iq_pc_n = IQ_pc;
    req_n   = MC_req_valid;
    addr_n  = MC_addr;
    fill    = 1'b0;
    if (clear) begin
      pc_n    = clear_pc;
      valid_n = 1'b0;
      req_n   = 1'b0;
      state_n = IF_IDLE;
    end else if (rdy) begin
      unique case (state)
        IF_IDLE: begin
          unique case (1'b1)
            IQ_queue_is_full: begin
              valid_n = 1'b0;
            end
            !IQ_queue_is_full && hit: begin
              valid_n = 1'b1;
              inst_n  = line;
              iq_pc_n = pc;
              pc_n    = pc + 32'd4;
            end
            !IQ_queue_is_full && !hit: begin
              valid_n = 1'b0;
              req_n   = 1'b1;
              addr_n  = word_addr(pc);
              state_n = IF_MISS;
            end
            default: ;
          endcase
        end
        IF_MISS: begin
          valid_n = 1'b0;
          if (MC_ack) begin
            fill    = 1'b1;
            req_n   = 1'b0;
            state_n = IF_IDLE;
          end
        end
        default: state_n = IF_IDLE;
      endcase
    end
  end

endmodule
